// File: rtl/ten_gig_eth_pcs_pma_gt_reset_seq.sv
// Transceiver reset sequencer for the 10G PCS/PMA datapath: waits for PLL lock,
// pulses the GT reset, waits for TX/RX reset-done with bounded retries, then releases PCS reset.
module ten_gig_eth_pcs_pma_gt_reset_seq #(
  parameter int C_LOCK_SETTLE  = 64,
  parameter int C_RESET_HOLD   = 16,
  parameter int C_DONE_TIMEOUT = 65535,
  parameter int C_MAX_RETRIES  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       soft_restart,
  input  logic       pll_lock_sync,
  input  logic       tx_resetdone_sync,
  input  logic       rx_resetdone_sync,
  output logic       gt_reset,
  output logic       pcs_reset,
  output logic       reset_done,
  output logic       fail,
  output logic [2:0] retry_cnt
);

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    SETTLE    = 3'd1,
    GT_RST    = 3'd2,
    WAIT_DONE = 3'd3,
    PCS_RST   = 3'd4,
    READY     = 3'd5,
    FAIL      = 3'd6
  } state_t;

  localparam logic [19:0] SETTLE_LAST  = 20'(C_LOCK_SETTLE - 1);
  localparam logic [19:0] HOLD_LAST    = 20'(C_RESET_HOLD - 1);
  localparam logic [19:0] TIMEOUT_LAST = 20'(C_DONE_TIMEOUT - 1);
  localparam logic [2:0]  RETRY_MAX    = 3'(C_MAX_RETRIES);

  state_t      state;
  state_t      nxt;
  logic [19:0] cnt;
  logic [2:0]  retry_nxt;
  logic        done_both;

  assign done_both = tx_resetdone_sync & rx_resetdone_sync;

  always_comb begin
    nxt       = state;
    retry_nxt = retry_cnt;
    if (soft_restart) begin
      nxt       = WAIT_LOCK;
      retry_nxt = 3'd0;
    end else if (!pll_lock_sync && state != WAIT_LOCK && state != FAIL) begin
      nxt = WAIT_LOCK;
    end else begin
      case (state)
        WAIT_LOCK: if (pll_lock_sync) nxt = SETTLE;
        SETTLE:    if (cnt == SETTLE_LAST) nxt = GT_RST;
        GT_RST:    if (cnt == HOLD_LAST) nxt = WAIT_DONE;
        WAIT_DONE: begin
          // A done arriving on the timeout cycle takes precedence over the retry.
          if (done_both) begin
            nxt = PCS_RST;
          end else if (cnt == TIMEOUT_LAST) begin
            if (retry_cnt == RETRY_MAX) begin
              nxt = FAIL;
            end else begin
              nxt       = GT_RST;
              retry_nxt = retry_cnt + 3'd1;
            end
          end
        end
        PCS_RST: begin
          if (!done_both) begin
            nxt = GT_RST;
          end else if (cnt == HOLD_LAST) begin
            nxt       = READY;
            retry_nxt = 3'd0;
          end
        end
        READY:   if (!done_both) nxt = WAIT_LOCK;
        FAIL:    nxt = FAIL;
        default: nxt = WAIT_LOCK;
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= WAIT_LOCK;
      cnt        <= 20'd0;
      retry_cnt  <= 3'd0;
      gt_reset   <= 1'b1;
      pcs_reset  <= 1'b1;
      reset_done <= 1'b0;
      fail       <= 1'b0;
    end else begin
      state     <= nxt;
      retry_cnt <= retry_nxt;
      if (nxt != state) begin
        cnt <= 20'd0;
      end else if (cnt != 20'hFFFFF) begin
        cnt <= cnt + 20'd1;
      end
      gt_reset   <= (nxt == WAIT_LOCK) || (nxt == SETTLE) || (nxt == GT_RST) || (nxt == FAIL);
      pcs_reset  <= (nxt != READY);
      reset_done <= (nxt == READY);
      fail       <= (nxt == FAIL);
    end
  end

endmodule
